// File: rtl/vga_plot_sequencer_if.sv
// Request channels, clear control and adapter-side pixel port of vga_plot_sequencer.
interface vga_plot_sequencer_if;
  logic       clear_req;
  logic       food_valid;
  logic       food_ready;
  logic [7:0] food_x;
  logic [6:0] food_y;
  logic [2:0] food_colour;
  logic       snake_valid;
  logic       snake_ready;
  logic [7:0] snake_x;
  logic [6:0] snake_y;
  logic [2:0] snake_colour;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;
  logic       vga_plot;
  logic       busy;
  logic [3:0] fifo_level;

  modport master (
    output clear_req,
    output food_valid, food_x, food_y, food_colour,
    output snake_valid, snake_x, snake_y, snake_colour,
    input  food_ready, snake_ready,
    input  vga_x, vga_y, vga_colour, vga_plot, busy, fifo_level
  );

  modport slave (
    input  clear_req,
    input  food_valid, food_x, food_y, food_colour,
    input  snake_valid, snake_x, snake_y, snake_colour,
    output food_ready, snake_ready,
    output vga_x, vga_y, vga_colour, vga_plot, busy, fifo_level
  );
endinterface

// File: rtl/vga_plot_sequencer.sv
// Arbitrates food/snake pixel requests into a FIFO and streams them to the VGA adapter,
// with a full-screen clear sweep after reset and on clear_req.
module vga_plot_sequencer #(
  parameter int unsigned FIFO_DEPTH   = 8,
  parameter int unsigned SCREEN_W     = 160,
  parameter int unsigned SCREEN_H     = 120,
  parameter logic [2:0]  CLEAR_COLOUR = 3'b000
) (
  input logic                 clk,
  input logic                 reset_n,
  vga_plot_sequencer_if.slave bus
);
  localparam int unsigned PW       = $clog2(FIFO_DEPTH);
  localparam logic [7:0]  X_LAST   = 8'(SCREEN_W - 1);
  localparam logic [6:0]  Y_LAST   = 7'(SCREEN_H - 1);
  localparam logic [3:0]  LVL_FULL = 4'(FIFO_DEPTH);

  typedef enum logic {ST_CLEAR, ST_RUN} state_t;
  typedef struct packed {
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
  } pixel_t;

  pixel_t fifo_mem [FIFO_DEPTH];

  state_t        state_q, state_d;
  logic [7:0]    cx_q, cx_d;
  logic [6:0]    cy_q, cy_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [3:0]    level_q, level_d;
  logic [7:0]    vga_x_q, vga_x_d;
  logic [6:0]    vga_y_q, vga_y_d;
  logic [2:0]    vga_colour_q, vga_colour_d;
  logic          vga_plot_q, vga_plot_d;

  logic   full, run, food_ready, snake_ready, push_food, push, pop;
  pixel_t push_px, head;

  always_comb begin
    full        = (level_q == LVL_FULL);
    run         = (state_q == ST_RUN);
    food_ready  = run && !full && !bus.clear_req;
    snake_ready = food_ready && !bus.food_valid;
    push_food   = bus.food_valid && food_ready;
    push        = push_food || (bus.snake_valid && snake_ready);
    push_px     = push_food ? {bus.food_x, bus.food_y, bus.food_colour}
                            : {bus.snake_x, bus.snake_y, bus.snake_colour};
    // Full is judged on registered occupancy, so a same-edge pop never frees a slot early.
    pop         = run && !bus.clear_req && (level_q != '0);
    head        = fifo_mem[rd_ptr_q];

    state_d      = state_q;
    cx_d         = cx_q;
    cy_d         = cy_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    level_d      = level_q;
    vga_x_d      = vga_x_q;
    vga_y_d      = vga_y_q;
    vga_colour_d = vga_colour_q;
    vga_plot_d   = 1'b0;

    if (bus.clear_req) begin
      state_d  = ST_CLEAR;
      cx_d     = '0;
      cy_d     = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else if (state_q == ST_CLEAR) begin
      vga_plot_d   = 1'b1;
      vga_x_d      = cx_q;
      vga_y_d      = cy_q;
      vga_colour_d = CLEAR_COLOUR;
      if (cx_q == X_LAST) begin
        cx_d = '0;
        if (cy_q == Y_LAST) begin
          cy_d    = '0;
          state_d = ST_RUN;
        end else begin
          cy_d = cy_q + 7'd1;
        end
      end else begin
        cx_d = cx_q + 8'd1;
      end
    end else begin
      if (pop) begin
        // Off-screen entries still drain and load the bus, but never strobe the adapter.
        vga_x_d      = head.x;
        vga_y_d      = head.y;
        vga_colour_d = head.colour;
        vga_plot_d   = (head.x <= X_LAST) && (head.y <= Y_LAST);
        rd_ptr_d     = rd_ptr_q + PW'(1);
      end
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      level_d = level_q + 4'(push) - 4'(pop);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_CLEAR;
      cx_q         <= '0;
      cy_q         <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      vga_x_q      <= '0;
      vga_y_q      <= '0;
      vga_colour_q <= '0;
      vga_plot_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cx_q         <= cx_d;
      cy_q         <= cy_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      level_q      <= level_d;
      vga_x_q      <= vga_x_d;
      vga_y_q      <= vga_y_d;
      vga_colour_q <= vga_colour_d;
      vga_plot_q   <= vga_plot_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= push_px;
  end

  assign bus.food_ready  = food_ready;
  assign bus.snake_ready = snake_ready;
  assign bus.vga_x       = vga_x_q;
  assign bus.vga_y       = vga_y_q;
  assign bus.vga_colour  = vga_colour_q;
  assign bus.vga_plot    = vga_plot_q;
  assign bus.busy        = (state_q == ST_CLEAR);
  assign bus.fifo_level  = level_q;
endmodule

// File: tb/tb_vga_plot_sequencer.sv
// Directed self-checking bench for vga_plot_sequencer: sweeps, arbitration, range filtering, clears, reset.
module tb_vga_plot_sequencer;
  logic clk;
  logic reset_n;
  int   checks;
  int   failures;

  logic [17:0] food_q[$];
  logic [17:0] snake_q[$];
  logic [17:0] last_out;

  vga_plot_sequencer_if bus ();

  vga_plot_sequencer #(
    .FIFO_DEPTH  (8),
    .SCREEN_W    (160),
    .SCREEN_H    (120),
    .CLEAR_COLOUR(3'b000)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic inr(input logic [17:0] e);
    return (e[17:10] < 8'd160) && (e[9:3] < 7'd120);
  endfunction

  // Called at the negedge showing (0,0); returns at the negedge after (159,119).
  task automatic sweep(input string tag);
    logic [7:0] ex;
    logic [6:0] ey;
    for (int i = 0; i < 19200; i++) begin
      ex = 8'(i % 160);
      ey = 7'(i / 160);
      chk({tag, "_pix"}, 32'({bus.vga_plot, bus.vga_x, bus.vga_y, bus.vga_colour}),
          32'({1'b1, ex, ey, 3'b000}));
      if (i < 19199) chk({tag, "_busy"}, 32'(bus.busy), 32'd1);
      @(negedge clk);
    end
    chk({tag, "_end_plot"}, 32'(bus.vga_plot), 32'd0);
    chk({tag, "_end_busy"}, 32'(bus.busy), 32'd0);
    chk({tag, "_end_ready"}, 32'(bus.food_ready), 32'd1);
    last_out = {8'd159, 7'd119, 3'd0};
  endtask

  // Pops run every cycle, so an entry accepted at edge k is shown after edge k+1.
  task automatic stream(input string tag);
    logic [17:0] p1, p2;
    logic        p1_v, p2_v;
    bit          done;
    p1 = '0; p2 = '0; p1_v = 1'b0; p2_v = 1'b0; done = 1'b0;
    for (int cyc = 0; cyc < 100 && !done; cyc++) begin
      if (p2_v) begin
        chk({tag, "_plot"}, 32'(bus.vga_plot), 32'(inr(p2)));
        last_out = p2;
      end else begin
        chk({tag, "_plot"}, 32'(bus.vga_plot), 32'd0);
      end
      chk({tag, "_data"}, 32'({bus.vga_x, bus.vga_y, bus.vga_colour}), 32'(last_out));
      chk({tag, "_level"}, 32'(bus.fifo_level), 32'(p1_v));
      if (!p1_v && !p2_v && food_q.size() == 0 && snake_q.size() == 0) begin
        done = 1'b1;
      end else begin
        bus.food_valid  = (food_q.size() != 0);
        bus.snake_valid = (snake_q.size() != 0);
        if (bus.food_valid)  {bus.food_x, bus.food_y, bus.food_colour} = food_q[0];
        if (bus.snake_valid) {bus.snake_x, bus.snake_y, bus.snake_colour} = snake_q[0];
        #1;
        if (bus.food_valid)  chk({tag, "_food_rdy"}, 32'(bus.food_ready), 32'd1);
        if (bus.snake_valid) chk({tag, "_snake_rdy"}, 32'(bus.snake_ready), 32'(!bus.food_valid));
        p2 = p1; p2_v = p1_v; p1_v = 1'b0;
        if (bus.food_valid && bus.food_ready) begin
          p1 = food_q.pop_front(); p1_v = 1'b1;
        end else if (bus.snake_valid && bus.snake_ready) begin
          p1 = snake_q.pop_front(); p1_v = 1'b1;
        end
        @(negedge clk);
      end
    end
    bus.food_valid  = 1'b0;
    bus.snake_valid = 1'b0;
    chk({tag, "_done"}, 32'(done), 32'd1);
  endtask

  initial begin
    checks = 0; failures = 0; last_out = '0;
    reset_n = 1'b0;
    bus.clear_req = 1'b0;
    bus.food_valid = 1'b0; bus.food_x = '0; bus.food_y = '0; bus.food_colour = '0;
    bus.snake_valid = 1'b0; bus.snake_x = '0; bus.snake_y = '0; bus.snake_colour = '0;

    // Reset state
    @(negedge clk); @(negedge clk);
    chk("rst_xyc", 32'({bus.vga_x, bus.vga_y, bus.vga_colour}), 32'd0);
    chk("rst_plot", 32'(bus.vga_plot), 32'd0);
    chk("rst_level", 32'(bus.fifo_level), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd1);
    chk("rst_food_rdy", 32'(bus.food_ready), 32'd0);
    chk("rst_snake_rdy", 32'(bus.snake_ready), 32'd0);

    // Power-on clear sweep
    reset_n = 1'b1;
    @(negedge clk);
    sweep("sweep0");

    // Single snake pixel
    snake_q.push_back({8'd12, 7'd34, 3'b111});
    stream("single");

    // Both channels loaded: food wins every cycle until it drains
    for (int i = 0; i < 8; i++) begin
      food_q.push_back({8'(20 + i), 7'(10 + i), 3'(i)});
      snake_q.push_back({8'(100 + i), 7'(60 + i), 3'(7 - i)});
    end
    stream("arb");

    // Nine back-to-back food pixels
    for (int i = 0; i < 9; i++) food_q.push_back({8'(40 + i), 7'(i), 3'(i + 1)});
    stream("burst");

    // Off-screen entries drain silently; the next legal one plots
    food_q.push_back({8'd160, 7'd5, 3'b100});
    food_q.push_back({8'd5, 7'd120, 3'b100});
    food_q.push_back({8'd7, 7'd8, 3'b101});
    stream("range");
    chk("range_last_x", 32'(bus.vga_x), 32'd7);

    // clear_req with an entry pending, refused same-cycle request
    bus.food_valid = 1'b1; {bus.food_x, bus.food_y, bus.food_colour} = {8'd30, 7'd30, 3'd1};
    @(negedge clk);
    chk("clr_pending_level", 32'(bus.fifo_level), 32'd1);
    {bus.food_x, bus.food_y, bus.food_colour} = {8'd31, 7'd31, 3'd2};
    bus.clear_req = 1'b1;
    #1;
    chk("clr_food_rdy", 32'(bus.food_ready), 32'd0);
    chk("clr_snake_rdy", 32'(bus.snake_ready), 32'd0);
    @(negedge clk);
    bus.clear_req = 1'b0; bus.food_valid = 1'b0;
    chk("clr1_level", 32'(bus.fifo_level), 32'd0);
    chk("clr1_plot", 32'(bus.vga_plot), 32'd0);
    chk("clr1_busy", 32'(bus.busy), 32'd1);
    @(negedge clk);

    // Partial sweep, then restart at pixel 500
    for (int i = 0; i <= 500; i++) begin
      chk("part_pix", 32'({bus.vga_plot, bus.vga_x, bus.vga_y, bus.vga_colour}),
          32'({1'b1, 8'(i % 160), 7'(i / 160), 3'b000}));
      if (i < 500) @(negedge clk);
    end
    bus.clear_req = 1'b1;
    @(negedge clk);
    bus.clear_req = 1'b0;
    chk("clr2_level", 32'(bus.fifo_level), 32'd0);
    chk("clr2_plot", 32'(bus.vga_plot), 32'd0);
    chk("clr2_busy", 32'(bus.busy), 32'd1);
    @(negedge clk);
    sweep("sweep1");
    chk("post_clr_idle", 32'(bus.fifo_level), 32'd0);

    // Asynchronous reset between edges with a request just pushed
    bus.food_valid = 1'b1; {bus.food_x, bus.food_y, bus.food_colour} = {8'd50, 7'd50, 3'd3};
    @(posedge clk);
    #2;
    bus.food_valid = 1'b0;
    reset_n = 1'b0;
    #1;
    chk("arst_xyc", 32'({bus.vga_x, bus.vga_y, bus.vga_colour}), 32'd0);
    chk("arst_plot", 32'(bus.vga_plot), 32'd0);
    chk("arst_level", 32'(bus.fifo_level), 32'd0);
    chk("arst_busy", 32'(bus.busy), 32'd1);
    chk("arst_food_rdy", 32'(bus.food_ready), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      chk("arst_pix", 32'({bus.vga_plot, bus.vga_x, bus.vga_y, bus.vga_colour}),
          32'({1'b1, 8'(i), 7'd0, 3'b000}));
      @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
